// File: rtl/scan_test_controller.sv
// Tester-side scan driver: loads an operand pair into the multiplier chain, pulses capture,
// unloads the product and checks it against a locally computed a*b.
module scan_test_controller #(
    parameter int unsigned W      = 4,
    parameter int unsigned FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      a_in,
    input  logic [W-1:0]      b_in,
    output logic              scan_in,
    output logic              scan_en,
    input  logic              scan_out,
    output logic              busy,
    output logic              done,
    output logic [2*W-1:0]    result,
    output logic              pass,
    output logic [FCNT_W-1:0] fail_count
);

    localparam int unsigned CW    = 2 * W;
    localparam int unsigned CNT_W = (CW > 1) ? $clog2(CW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_UNLOAD  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state,      state_d;
    logic [CNT_W-1:0]  bit_cnt,    bit_cnt_d;
    logic [W-1:0]      op_a,       op_a_d;
    logic [W-1:0]      op_b,       op_b_d;
    logic [CW-1:0]     load_sr,    load_sr_d;
    logic [CW-1:0]     shadow,     shadow_d;
    logic              scan_in_d,  scan_en_d, busy_d, done_d, pass_d;
    logic [CW-1:0]     result_d;
    logic [FCNT_W-1:0] fail_count_d;

    logic [CW-1:0] expected;
    logic [CW-1:0] unload_word;

    assign expected    = CW'(op_a) * CW'(op_b);
    // Tail bit enters at the top so the first sample ends up as the LSB
    assign unload_word = {scan_out, shadow[CW-1:1]};

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        bit_cnt_d    = bit_cnt;
        op_a_d       = op_a;
        op_b_d       = op_b;
        load_sr_d    = load_sr;
        shadow_d     = shadow;
        scan_in_d    = 1'b0;
        scan_en_d    = 1'b0;
        busy_d       = busy;
        done_d       = 1'b0;
        result_d     = result;
        pass_d       = pass;
        fail_count_d = fail_count;

        case (state)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d   = S_LOAD;
                    op_a_d    = a_in;
                    op_b_d    = b_in;
                    load_sr_d = {a_in, b_in} >> 1;
                    scan_in_d = b_in[0];
                    scan_en_d = 1'b1;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            S_LOAD: begin
                busy_d = 1'b1;
                if (bit_cnt == CNT_LAST) begin
                    state_d   = S_CAPTURE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt + CNT_W'(1);
                    scan_en_d = 1'b1;
                    scan_in_d = load_sr[0];
                    load_sr_d = load_sr >> 1;
                end
            end
            S_CAPTURE: begin
                busy_d    = 1'b1;
                state_d   = S_UNLOAD;
                bit_cnt_d = '0;
                scan_en_d = 1'b1;
            end
            S_UNLOAD: begin
                busy_d   = 1'b1;
                shadow_d = unload_word;
                if (bit_cnt == CNT_LAST) begin
                    state_d   = S_DONE;
                    bit_cnt_d = '0;
                    done_d    = 1'b1;
                    result_d  = unload_word;
                    pass_d    = (unload_word == expected);
                    if ((unload_word != expected) && (fail_count != '1))
                        fail_count_d = fail_count + FCNT_W'(1);
                end else begin
                    bit_cnt_d = bit_cnt + CNT_W'(1);
                    scan_en_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                bit_cnt_d = '0;
            end
            default: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            load_sr    <= '0;
            shadow     <= '0;
            scan_in    <= 1'b0;
            scan_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            pass       <= 1'b0;
            fail_count <= '0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            op_a       <= op_a_d;
            op_b       <= op_b_d;
            load_sr    <= load_sr_d;
            shadow     <= shadow_d;
            scan_in    <= scan_in_d;
            scan_en    <= scan_en_d;
            busy       <= busy_d;
            done       <= done_d;
            result     <= result_d;
            pass       <= pass_d;
            fail_count <= fail_count_d;
        end
    end

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller: drives patterns into a behavioural 4x4 multiplier scan chain
// (optionally with product bit 3 stuck-at-0) and checks results against an arithmetic model.
module tb_scan_test_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a_in = '0;
    logic [3:0] b_in = '0;
    logic       scan_in, scan_en, scan_out, busy, done, pass;
    logic [7:0] result;
    logic [7:0] fail_count;

    int total = 0;
    int bad   = 0;
    int model_fc = 0;
    bit fault = 1'b0;

    logic [7:0] chain = '0;

    scan_test_controller #(.W(4), .FCNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .scan_in(scan_in), .scan_en(scan_en), .scan_out(scan_out),
        .busy(busy), .done(done), .result(result), .pass(pass),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // Chain under test: shift toward the tail when scan_en, otherwise capture {a,b} -> a*b
    assign scan_out = chain[0];
    always @(posedge clk) begin
        if (scan_en) chain <= {scan_in, chain[7:1]};
        else if (fault) chain <= (8'(chain[7:4]) * 8'(chain[3:0])) & 8'hF7;
        else chain <= 8'(chain[7:4]) * 8'(chain[3:0]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] chain_product(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'(a) * 8'(b);
        return fault ? (p & 8'hF7) : p;
    endfunction

    // Runs one pattern; returns in the done cycle (or after the bound expires, lat = -1)
    task automatic do_pattern(input logic [3:0] a, input logic [3:0] b,
                              output logic [7:0] res, output logic p,
                              output logic [7:0] fc, output int lat, output int bcyc);
        a_in = a; b_in = b; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        bcyc = busy ? 1 : 0;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (busy) bcyc++;
        end
        if (!done) lat = -1;
        res = result; p = pass; fc = fail_count;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({scan_en, scan_in, busy, done, pass} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got en=%b in=%b busy=%b done=%b pass=%b exp all 0",
                     scan_en, scan_in, busy, done, pass);
        end
        total++;
        if (result !== 8'h00 || fail_count !== 8'h00) begin
            bad++;
            $display("FAIL reset_regs got result=%h fc=%0d exp 00/0", result, fail_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        int lat;
        pat = {4'd5, 4'd6};
        a_in = 4'd5; b_in = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (scan_en !== 1'b1 || scan_in !== pat[k]) begin
                bad++;
                $display("FAIL basic_load bit%0d got en=%b in=%b exp en=1 in=%b",
                         k, scan_en, scan_in, pat[k]);
            end
            step();
        end
        total++;
        if (scan_en !== 1'b0 || scan_in !== 1'b0) begin
            bad++;
            $display("FAIL basic_capture got en=%b in=%b exp 0/0", scan_en, scan_in);
        end
        step();
        total++;
        if (scan_en !== 1'b1) begin
            bad++;
            $display("FAIL basic_unload_en got %b exp 1", scan_en);
        end
        lat = 9;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        total++;
        if (lat !== 17) begin
            bad++;
            $display("FAIL basic_latency got %0d exp 17", lat);
        end
        total++;
        if (result !== 8'h1E || pass !== 1'b1 || fail_count !== 8'd0) begin
            bad++;
            $display("FAIL basic_result got %h pass=%b fc=%0d exp 1e/1/0", result, pass, fail_count);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_after got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic test_patterns(input int n, input bit corners);
        logic [3:0] a, b;
        logic [7:0] res, fc, exp_res;
        logic p;
        int lat, bcyc;
        for (int i = 0; i < n; i++) begin
            if (corners) begin
                a = (i == 0) ? 4'd15 : 4'd0;
                b = a;
            end else begin
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
            end
            do_pattern(a, b, res, p, fc, lat, bcyc);
            exp_res = chain_product(a, b);
            total++;
            if (res !== exp_res || p !== (exp_res == 8'(a) * 8'(b))) begin
                bad++;
                $display("FAIL pattern_%0dx%0d got %h pass=%b exp %h", a, b, res, p, exp_res);
            end
            total++;
            if (lat !== 17 || bcyc !== 18) begin
                bad++;
                $display("FAIL pattern_timing got lat=%0d busy=%0d exp 17/18", lat, bcyc);
            end
            total++;
            if (fc !== 8'(model_fc)) begin
                bad++;
                $display("FAIL pattern_fc got %0d exp %0d", fc, model_fc);
            end
            step();
        end
    endtask

    task automatic test_busy_start();
        int dones, cyc;
        logic [7:0] seen;
        seen = 8'h00;
        a_in = 4'd5; b_in = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        a_in = 4'd3; b_in = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        dones = 0;
        for (cyc = 0; cyc < 45; cyc++) begin
            if (done) begin
                dones++;
                seen = result;
            end
            step();
        end
        total++;
        if (dones !== 1 || seen !== 8'h1E) begin
            bad++;
            $display("FAIL busy_start got dones=%0d result=%h exp 1/1e", dones, seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] res, fc;
        logic p;
        int lat, bcyc;
        do_pattern(4'd7, 4'd9, res, p, fc, lat, bcyc);
        total++;
        if (res !== 8'd63 || p !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got %h pass=%b exp 3f/1", res, p);
        end
        a_in = 4'd2; b_in = 4'd3; start = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_start_ignored got busy=%b exp 0", busy);
        end
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle_accept got busy=%b exp 1", busy);
        end
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        total++;
        if (lat !== 17 || result !== 8'd6) begin
            bad++;
            $display("FAIL b2b_second got lat=%0d result=%h exp 17/06", lat, result);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [7:0] res, fc;
        logic p;
        int lat, bcyc, dones;
        a_in = 4'd5; b_in = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (scan_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || fail_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid got en=%b busy=%b done=%b fc=%0d exp 0/0/0/0",
                     scan_en, busy, done, fail_count);
        end
        dones = 0;
        repeat (30) begin
            step();
            if (done) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL reset_mid_no_done got %0d dones exp 0", dones);
        end
        do_pattern(4'd5, 4'd6, res, p, fc, lat, bcyc);
        total++;
        if (res !== 8'h1E || p !== 1'b1 || lat !== 17) begin
            bad++;
            $display("FAIL reset_mid_rerun got %h pass=%b lat=%0d exp 1e/1/17", res, p, lat);
        end
        step();
    endtask

    task automatic test_fault();
        logic [7:0] res, fc;
        logic p;
        int lat, bcyc;
        fault = 1'b1;
        for (int i = 0; i < 300; i++) begin
            do_pattern(4'd5, 4'd6, res, p, fc, lat, bcyc);
            if (model_fc < 255) model_fc++;
            if (i == 0) begin
                total++;
                if (res !== 8'h16 || p !== 1'b0) begin
                    bad++;
                    $display("FAIL fault_result got %h pass=%b exp 16/0", res, p);
                end
            end
            total++;
            if (fc !== 8'(model_fc)) begin
                bad++;
                $display("FAIL fault_count run%0d got %0d exp %0d", i, fc, model_fc);
            end
            step();
        end
        total++;
        if (fail_count !== 8'd255) begin
            bad++;
            $display("FAIL fault_saturate got %0d exp 255", fail_count);
        end
        fault = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns(2, 1'b1);
        test_patterns(20, 1'b0);
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_fault();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
